// File: rtl/approx_adder_error_monitor_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
package approx_adder_error_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } monState_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 16;

   // One extra bit on top of an accumulator exposes the carry used to saturate.
   function automatic int satAddWidth(input int w);
      return w + 1;
   endfunction

endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// Sample stream (producer -> monitor) and result stream (monitor -> consumer).
interface approx_adder_error_monitor_if
   import approx_adder_error_monitor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);

   localparam int SUM_W = CNT_W + WIDTH + 1;
   localparam int SQ_W  = CNT_W + 2 * (WIDTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH:0]   in_approx;

   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_err_count;
   logic [WIDTH:0]   res_max_ed;
   logic [SUM_W-1:0] res_sum_ed;
   logic [SQ_W-1:0]  res_sum_sq;

   modport master (
      output in_valid, in_a, in_b, in_approx, res_ready,
      input  in_ready, res_valid, res_err_count, res_max_ed, res_sum_ed, res_sum_sq
   );

   modport slave (
      input  in_valid, in_a, in_b, in_approx, res_ready,
      output in_ready, res_valid, res_err_count, res_max_ed, res_sum_ed, res_sum_sq
   );

endinterface

// File: rtl/approx_adder_error_monitor_datapath.sv
// Two-stage error pipeline: S1 forms |exact - approx|, S2 squares it.
module approx_err_datapath
   import approx_adder_error_monitor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_i,
   input  logic [WIDTH-1:0]       a_i,
   input  logic [WIDTH-1:0]       b_i,
   input  logic [WIDTH:0]         approx_i,
   output logic                   valid_o,
   output logic                   nz_o,
   output logic [WIDTH:0]         ed_o,
   output logic [2*(WIDTH+1)-1:0] sq_o
);

   localparam int SQ_PW = 2 * (WIDTH + 1);

   logic [WIDTH:0]   exactSum;
   logic [WIDTH:0]   ed_d;
   logic [SQ_PW-1:0] sq_d;

   logic             s1Valid_q;
   logic             s1Nz_q;
   logic [WIDTH:0]   s1Ed_q;
   logic             s2Valid_q;
   logic             s2Nz_q;
   logic [WIDTH:0]   s2Ed_q;
   logic [SQ_PW-1:0] s2Sq_q;

   // The exact sum is only needed to form the distance, so it is folded into S1.
   always_comb begin
      exactSum = {1'b0, a_i} + {1'b0, b_i};
      ed_d     = (exactSum >= approx_i) ? (exactSum - approx_i) : (approx_i - exactSum);
      sq_d     = SQ_PW'(s1Ed_q) * SQ_PW'(s1Ed_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s1Nz_q    <= 1'b0;
         s1Ed_q    <= '0;
         s2Valid_q <= 1'b0;
         s2Nz_q    <= 1'b0;
         s2Ed_q    <= '0;
         s2Sq_q    <= '0;
      end else begin
         s1Valid_q <= valid_i;
         s1Nz_q    <= (ed_d != '0);
         s1Ed_q    <= ed_d;
         s2Valid_q <= s1Valid_q;
         s2Nz_q    <= s1Nz_q;
         s2Ed_q    <= s1Ed_q;
         s2Sq_q    <= sq_d;
      end
   end

   assign valid_o = s2Valid_q;
   assign nz_o    = s2Nz_q;
   assign ed_o    = s2Ed_q;
   assign sq_o    = s2Sq_q;

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Window controller and saturating error accumulators for approximate-adder characterisation.
module approx_adder_error_monitor
   import approx_adder_error_monitor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W,
   parameter int SUM_W = CNT_W + WIDTH + 1,
   parameter int SQ_W  = CNT_W + 2 * (WIDTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [CNT_W-1:0]           num_samples,
   output logic                       busy,
   approx_adder_error_monitor_if.slave bus
);

   localparam int CNT_AW = satAddWidth(CNT_W);
   localparam int SUM_AW = satAddWidth(SUM_W);
   localparam int SQ_AW  = satAddWidth(SQ_W);
   localparam int SQ_PW  = 2 * (WIDTH + 1);

   monState_e        state_q;
   logic [CNT_W-1:0] remaining_q;
   logic             drainCnt_q;
   logic             inReady_q;
   logic             busy_q;
   logic             resValid_q;

   logic [CNT_W-1:0] errCount_q, errCount_d;
   logic [WIDTH:0]   maxEd_q, maxEd_d;
   logic [SUM_W-1:0] sumEd_q, sumEd_d;
   logic [SQ_W-1:0]  sumSq_q, sumSq_d;

   logic [CNT_AW-1:0] cntWide;
   logic [SUM_AW-1:0] sumWide;
   logic [SQ_AW-1:0]  sqWide;

   logic             accept;
   logic             dpValid;
   logic             dpNz;
   logic [WIDTH:0]   dpEd;
   logic [SQ_PW-1:0] dpSq;

   assign accept = bus.in_valid && inReady_q;

   approx_err_datapath #(.WIDTH(WIDTH)) uDatapath (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (accept),
      .a_i      (bus.in_a),
      .b_i      (bus.in_b),
      .approx_i (bus.in_approx),
      .valid_o  (dpValid),
      .nz_o     (dpNz),
      .ed_o     (dpEd),
      .sq_o     (dpSq)
   );

   // DRAIN lasts two cycles so the final sample clears both pipeline stages before HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         drainCnt_q  <= 1'b0;
         inReady_q   <= 1'b0;
         busy_q      <= 1'b0;
         resValid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  remaining_q <= num_samples;
                  if (num_samples == '0) begin
                     state_q    <= HOLD;
                     resValid_q <= 1'b1;
                  end else begin
                     state_q   <= RUN;
                     inReady_q <= 1'b1;
                     busy_q    <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  remaining_q <= remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     state_q    <= DRAIN;
                     inReady_q  <= 1'b0;
                     drainCnt_q <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (drainCnt_q) begin
                  state_q    <= HOLD;
                  busy_q     <= 1'b0;
                  resValid_q <= 1'b1;
               end else begin
                  drainCnt_q <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.res_ready) begin
                  state_q    <= IDLE;
                  resValid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Each sum carries one spare bit; a set carry pins the result at all-ones.
   always_comb begin
      cntWide    = {1'b0, errCount_q} + CNT_AW'(dpNz);
      sumWide    = {1'b0, sumEd_q} + SUM_AW'(dpEd);
      sqWide     = {1'b0, sumSq_q} + SQ_AW'(dpSq);
      errCount_d = cntWide[CNT_W] ? '1 : cntWide[CNT_W-1:0];
      sumEd_d    = sumWide[SUM_W] ? '1 : sumWide[SUM_W-1:0];
      sumSq_d    = sqWide[SQ_W]   ? '1 : sqWide[SQ_W-1:0];
      maxEd_d    = (dpEd > maxEd_q) ? dpEd : maxEd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errCount_q <= '0;
         maxEd_q    <= '0;
         sumEd_q    <= '0;
         sumSq_q    <= '0;
      end else if (state_q == IDLE && start) begin
         errCount_q <= '0;
         maxEd_q    <= '0;
         sumEd_q    <= '0;
         sumSq_q    <= '0;
      end else if (dpValid) begin
         errCount_q <= errCount_d;
         maxEd_q    <= maxEd_d;
         sumEd_q    <= sumEd_d;
         sumSq_q    <= sumSq_d;
      end
   end

   assign busy              = busy_q;
   assign bus.in_ready      = inReady_q;
   assign bus.res_valid     = resValid_q;
   assign bus.res_err_count = errCount_q;
   assign bus.res_max_ed    = maxEd_q;
   assign bus.res_sum_ed    = sumEd_q;
   assign bus.res_sum_sq    = sumSq_q;

endmodule
